// File: rtl/bm_match2_seq_div.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define BM_SEQ_DIV_SIGNED_EN for two's-complement operands (magnitude core, sign fix-up).
module bm_match2_seq_div #(
    parameter int DIVIDEND_W = 18,
    parameter int DIVISOR_W  = 9
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dsr;
    logic [DIVISOR_W:0]    r_prem;

    logic                  w_accept;
    logic                  w_dsr_zero;
    logic                  w_dbz;
    logic [DIVISOR_W+1:0]  w_shift;
    logic [DIVISOR_W+1:0]  w_trial;
    logic                  w_ge;
    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dsr_mag;
    logic [DIVIDEND_W-1:0] w_q_res;
    logic [DIVISOR_W-1:0]  w_r_res;

    // A start coinciding with the done pulse is dropped; the next IDLE cycle accepts.
    assign w_accept   = (r_state == S_IDLE) && start && !done;
    assign w_dsr_zero = (divisor == '0);
    assign w_dbz      = (r_dsr == '0);

    // Partial remainder stays below the divisor, so the top bit of w_trial is a clean borrow.
    assign w_shift = {r_prem, r_dvd[DIVIDEND_W-1]};
    assign w_trial = w_shift - {2'b00, r_dsr};
    assign w_ge    = ~w_trial[DIVISOR_W+1];

`ifdef BM_SEQ_DIV_SIGNED_EN
    logic w_dvd_neg;
    logic w_dsr_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_neg = dividend[DIVIDEND_W-1];
    assign w_dsr_neg = divisor[DIVISOR_W-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dsr_mag = w_dsr_neg ? -divisor : divisor;
    assign w_q_res   = r_neg_q ? -r_dvd : r_dvd;
    assign w_r_res   = r_neg_r ? -r_prem[DIVISOR_W-1:0] : r_prem[DIVISOR_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_dvd_neg ^ w_dsr_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dsr_mag = divisor;
    assign w_q_res   = r_dvd;
    assign w_r_res   = r_prem[DIVISOR_W-1:0];
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_dsr_zero ? S_DONE : S_RUN;
            S_RUN:  if (r_cnt == CNT_W'(1)) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Quotient bits shift into r_dvd from the bottom as dividend bits leave the top.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_prem      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dsr  <= w_dsr_mag;
                        r_prem <= '0;
                        r_cnt  <= CNT_W'(DIVIDEND_W);
                        // Keep the raw dividend on divide-by-zero: its low bits become the remainder.
                        r_dvd  <= w_dsr_zero ? dividend : w_dvd_mag;
                        busy   <= !w_dsr_zero;
                    end
                end
                S_RUN: begin
                    r_prem <= w_ge ? w_trial[DIVISOR_W:0] : w_shift[DIVISOR_W:0];
                    r_dvd  <= {r_dvd[DIVIDEND_W-2:0], w_ge};
                    r_cnt  <= r_cnt - CNT_W'(1);
                end
                S_DONE: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    div_by_zero <= w_dbz;
                    if (w_dbz) begin
                        quotient  <= '1;
                        remainder <= r_dvd[DIVISOR_W-1:0];
                    end else begin
                        quotient  <= w_q_res;
                        remainder <= w_r_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bm_match2_seq_div.sv
// Self-checking bench for bm_match2_seq_div: vector table, corner sequences, random vs model.
module tb_bm_match2_seq_div;

    localparam int DW = 18;
    localparam int SW = 9;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [SW-1:0] divisor = '0;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;

    int checks = 0;
    int errors = 0;

    bm_match2_seq_div #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] a;
        logic [SW-1:0] b;
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic          z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [DW-1:0] a, input logic [SW-1:0] b,
                                  output logic [DW-1:0] q, output logic [SW-1:0] r,
                                  output logic z);
        logic [SW-1:0] low;
        low = a[SW-1:0];
        z = (b == '0);
        if (z) begin
            q = '1;
            r = low;
        end else begin
`ifdef BM_SEQ_DIV_SIGNED_EN
            int sa, sb;
            sa = int'($signed(a));
            sb = int'($signed(b));
            q = DW'(sa / sb);
            r = SW'(sa % sb);
`else
            q = a / DW'(b);
            r = SW'(a % DW'(b));
`endif
        end
    endfunction

    // Called #1 after a rising edge; returns with time #1 after the edge following the done pulse.
    task automatic run_div(input string tag, input logic [DW-1:0] a, input logic [SW-1:0] b,
                           input logic [DW-1:0] eq, input logic [SW-1:0] er, input logic ez);
        int lat;
        lat = -1;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        dividend = DW'($urandom);
        divisor = SW'($urandom);
        check({tag, " busy"}, 32'(busy), 32'(b != '0));
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), (b == '0) ? 32'd1 : 32'(DW + 1));
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " dbz"}, 32'(div_by_zero), 32'(ez));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clock); #1;
        check({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    vec_t vt[$];

    initial begin
        logic [DW-1:0] eq, ra;
        logic [SW-1:0] er, rb;
        logic          ez;
        int            ndone;

        repeat (3) @(posedge clock);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset dbz", 32'(div_by_zero), 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

`ifdef BM_SEQ_DIV_SIGNED_EN
        vt.push_back('{18'(-200), 9'd7, 18'(-28), 9'(-4), 1'b0});
        vt.push_back('{18'd200, 9'(-7), 18'(-28), 9'd4, 1'b0});
        vt.push_back('{18'h20000, 9'h1FF, 18'h20000, 9'd0, 1'b0});
        vt.push_back('{18'(-90), 9'(-9), 18'd10, 9'd0, 1'b0});
        vt.push_back('{18'd1000, 9'd0, 18'h3FFFF, 9'd488, 1'b1});
        vt.push_back('{18'd200, 9'd7, 18'd28, 9'd4, 1'b0});
`else
        vt.push_back('{18'd200, 9'd7, 18'd28, 9'd4, 1'b0});
        vt.push_back('{18'd261121, 9'd511, 18'd511, 9'd0, 1'b0});
        vt.push_back('{18'd0, 9'd5, 18'd0, 9'd0, 1'b0});
        vt.push_back('{18'd1000, 9'd0, 18'h3FFFF, 9'd488, 1'b1});
        vt.push_back('{18'd262143, 9'd1, 18'd262143, 9'd0, 1'b0});
        vt.push_back('{18'd5, 9'd511, 18'd0, 9'd5, 1'b0});
        vt.push_back('{18'd511, 9'd511, 18'd1, 9'd0, 1'b0});
        vt.push_back('{18'd90, 9'd9, 18'd10, 9'd0, 1'b0});
`endif
        foreach (vt[k]) begin
            run_div($sformatf("vec%0d", k), vt[k].a, vt[k].b, vt[k].q, vt[k].r, vt[k].z);
            repeat (3) @(posedge clock);
            #1;
            check($sformatf("vec%0d hold", k), 32'(quotient), 32'(vt[k].q));
        end

        // Start pulse mid-run is ignored.
        dividend = 18'd200; divisor = 9'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        dividend = 18'd50; divisor = 9'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("midstart busy", 32'(busy), 32'd1);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                ndone++;
                check("midstart quotient", 32'(quotient), 32'd28);
                check("midstart remainder", 32'(remainder), 32'd4);
            end
            @(posedge clock); #1;
        end
        check("midstart done count", 32'(ndone), 32'd1);

        // Start held through the done cycle: dropped there, taken on the next cycle.
        dividend = 18'd200; divisor = 9'd7; start = 1'b1;
        @(posedge clock); #1;
        ndone = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (done) begin
                ndone = i;
                break;
            end
        end
        check("b2b latency", 32'(ndone), 32'(DW + 1));
        dividend = 18'd50; divisor = 9'd3;
        @(posedge clock); #1;
        check("b2b ignored busy", 32'(busy), 32'd0);
        check("b2b ignored done", 32'(done), 32'd0);
        @(posedge clock); #1;
        start = 1'b0;
        check("b2b accepted busy", 32'(busy), 32'd1);
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clock); #1;
        end
        check("b2b quotient", 32'(quotient), 32'd16);
        check("b2b remainder", 32'(remainder), 32'd2);
        @(posedge clock); #1;

        // Asynchronous reset mid-run discards the operation.
        dividend = 18'd200; divisor = 9'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset quotient", 32'(quotient), 32'd0);
        check("midreset remainder", 32'(remainder), 32'd0);
        check("midreset dbz", 32'(div_by_zero), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_div("post_reset", 18'd90, 9'd9, 18'd10, 9'd0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if (n % 3 == 0) begin
                rb = SW'($urandom_range(1, (1 << SW) - 1));
                ra = DW'($urandom_range(0, (1 << SW) - 1)) * DW'(rb);
            end else begin
                ra = DW'($urandom);
                rb = ($urandom_range(0, 9) == 0) ? '0 : SW'($urandom);
            end
            model(ra, rb, eq, er, ez);
            run_div($sformatf("rand%0d", n), ra, rb, eq, er, ez);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
